sprite_anim_ctrl: RTL and testbench

SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

---
 rtl/sprite_anim_ctrl_pkg.sv | 68 ++++++
 rtl/sprite_anim_ctrl_seq.sv | 130 +++++++++++++
 rtl/sprite_anim_ctrl.sv | 76 +++++++
 tb/tb_sprite_anim_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_anim_ctrl_pkg.sv
// Shared encodings for the fighter animation path: request codes,
// sprite ROM select codes and the per-player sequencer state.
package sprite_anim_ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [3:0] REQ_IDLE  = 4'd0;
  localparam logic [3:0] REQ_FWD   = 4'd1;
  localparam logic [3:0] REQ_BACK  = 4'd2;
  localparam logic [3:0] REQ_ATK   = 4'd3;
  localparam logic [3:0] REQ_DIR   = 4'd4;
  localparam logic [3:0] REQ_BLOCK = 4'd5;

  typedef enum logic [3:0] {
    SEL_IDLE     = 4'd0,
    SEL_WALK     = 4'd1,
    SEL_WALKBACK = 4'd2,
    SEL_ATKSTART = 4'd3,
    SEL_ATKEND   = 4'd4,
    SEL_ATKPULL  = 4'd5,
    SEL_BLOCK    = 4'd6,
    SEL_DIRSTART = 4'd7,
    SEL_DIREND   = 4'd8,
    SEL_DIRPULL  = 4'd9,
    SEL_GOTHIT   = 4'd10
  } sel_e;

  typedef enum logic [2:0] {
    SEQ_IDLE_MOVE,
    SEQ_ATK_START,
    SEQ_ATK_END,
    SEQ_ATK_PULL,
    SEQ_DIR_START,
    SEQ_DIR_END,
    SEQ_DIR_PULL,
    SEQ_HIT
  } seq_state_e;

  function automatic logic is_attack(input seq_state_e st);
    return (st != SEQ_IDLE_MOVE) && (st != SEQ_HIT);
  endfunction

  // In IDLE_MOVE the pose mirrors the movement request; bad codes show idle.
  function automatic sel_e sel_for_state(input seq_state_e st, input logic [3:0] req);
    sel_e s;
    s = SEL_IDLE;
    case (st)
      SEQ_IDLE_MOVE: begin
        case (req)
          REQ_FWD:   s = SEL_WALK;
          REQ_BACK:  s = SEL_WALKBACK;
          REQ_BLOCK: s = SEL_BLOCK;
          default:   s = SEL_IDLE;
        endcase
      end
      SEQ_ATK_START: s = SEL_ATKSTART;
      SEQ_ATK_END:   s = SEL_ATKEND;
      SEQ_ATK_PULL:  s = SEL_ATKPULL;
      SEQ_DIR_START: s = SEL_DIRSTART;
      SEQ_DIR_END:   s = SEL_DIREND;
      SEQ_DIR_PULL:  s = SEL_DIRPULL;
      SEQ_HIT:       s = SEL_GOTHIT;
      default:       s = SEL_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl_seq.sv
// Per-player animation sequencer: attack/directional phase timing and
// got-hit override, all state committed only on frame_tick.
module sprite_seq
  import sprite_anim_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_START = 4,
  parameter int unsigned HOLD_END   = 3,
  parameter int unsigned HOLD_PULL  = 5,
  parameter int unsigned HOLD_HIT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [3:0] i_req,
  input  logic       i_hit,
  output logic [3:0] o_sel,
  output logic       o_busy,
  output logic       o_atk_nxt
);

  localparam logic [CNT_W-1:0] LD_START = CNT_W'(HOLD_START - 1);
  localparam logic [CNT_W-1:0] LD_END   = CNT_W'(HOLD_END - 1);
  localparam logic [CNT_W-1:0] LD_PULL  = CNT_W'(HOLD_PULL - 1);
  localparam logic [CNT_W-1:0] LD_HIT   = CNT_W'(HOLD_HIT - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  seq_state_e       w_idle_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_idle_cnt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             r_hit_pend;
  logic             w_hit;
  logic             w_cnt_zero;
  logic [3:0]       r_sel;
  logic             r_busy;

  assign w_hit      = r_hit_pend | i_hit;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_dec  = r_cnt - CNT_W'(1);

  // Where the sequencer lands when free to act on req (idle or hit expiry).
  always_comb begin
    w_idle_state = SEQ_IDLE_MOVE;
    w_idle_cnt   = '0;
    if (i_req == REQ_ATK) begin
      w_idle_state = SEQ_ATK_START;
      w_idle_cnt   = LD_START;
    end else if (i_req == REQ_DIR) begin
      w_idle_state = SEQ_DIR_START;
      w_idle_cnt   = LD_START;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_hit) begin
      w_state_nxt = SEQ_HIT;
      w_cnt_nxt   = LD_HIT;
    end else begin
      case (r_state)
        SEQ_IDLE_MOVE: begin
          w_state_nxt = w_idle_state;
          w_cnt_nxt   = w_idle_cnt;
        end
        SEQ_ATK_START, SEQ_DIR_START: begin
          if (w_cnt_zero) begin
            w_state_nxt = (r_state == SEQ_ATK_START) ? SEQ_ATK_END : SEQ_DIR_END;
            w_cnt_nxt   = LD_END;
          end else begin
            w_cnt_nxt   = w_cnt_dec;
          end
        end
        SEQ_ATK_END, SEQ_DIR_END: begin
          if (w_cnt_zero) begin
            w_state_nxt = (r_state == SEQ_ATK_END) ? SEQ_ATK_PULL : SEQ_DIR_PULL;
            w_cnt_nxt   = LD_PULL;
          end else begin
            w_cnt_nxt   = w_cnt_dec;
          end
        end
        SEQ_ATK_PULL, SEQ_DIR_PULL: begin
          if (w_cnt_zero) begin
            w_state_nxt = SEQ_IDLE_MOVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_dec;
          end
        end
        SEQ_HIT: begin
          if (w_cnt_zero) begin
            w_state_nxt = w_idle_state;
            w_cnt_nxt   = w_idle_cnt;
          end else begin
            w_cnt_nxt   = w_cnt_dec;
          end
        end
        default: begin
          w_state_nxt = SEQ_IDLE_MOVE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SEQ_IDLE_MOVE;
      r_cnt      <= '0;
      r_hit_pend <= 1'b0;
      r_sel      <= SEL_IDLE;
      r_busy     <= 1'b0;
    end else if (frame_tick) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hit_pend <= 1'b0;
      r_sel      <= sel_for_state(w_state_nxt, i_req);
      r_busy     <= (w_state_nxt != SEQ_IDLE_MOVE);
    end else if (i_hit) begin
      r_hit_pend <= 1'b1;
    end
  end

  assign o_sel     = r_sel;
  assign o_busy    = r_busy;
  assign o_atk_nxt = is_attack(w_state_nxt);

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Two-player sprite animation controller: one sequencer per fighter plus
// the draw-priority register that favours whoever is attacking alone.
module sprite_anim_ctrl
  import sprite_anim_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_START = 4,
  parameter int unsigned HOLD_END   = 3,
  parameter int unsigned HOLD_PULL  = 5,
  parameter int unsigned HOLD_HIT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [3:0] req1,
  input  logic [3:0] req2,
  input  logic       hit1,
  input  logic       hit2,
  output logic [3:0] sel1,
  output logic [3:0] sel2,
  output logic       busy1,
  output logic       busy2,
  output logic       top1
);

  logic w_atk1;
  logic w_atk2;
  logic r_top1;

  sprite_seq #(
    .HOLD_START(HOLD_START),
    .HOLD_END  (HOLD_END),
    .HOLD_PULL (HOLD_PULL),
    .HOLD_HIT  (HOLD_HIT)
  ) u_p1 (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .i_req     (req1),
    .i_hit     (hit1),
    .o_sel     (sel1),
    .o_busy    (busy1),
    .o_atk_nxt (w_atk1)
  );

  sprite_seq #(
    .HOLD_START(HOLD_START),
    .HOLD_END  (HOLD_END),
    .HOLD_PULL (HOLD_PULL),
    .HOLD_HIT  (HOLD_HIT)
  ) u_p2 (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .i_req     (req2),
    .i_hit     (hit2),
    .o_sel     (sel2),
    .o_busy    (busy2),
    .o_atk_nxt (w_atk2)
  );

  // Priority follows the post-tick states so it updates with the selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top1 <= 1'b1;
    end else if (frame_tick) begin
      if (w_atk1 && !w_atk2) begin
        r_top1 <= 1'b1;
      end else if (!w_atk1 && w_atk2) begin
        r_top1 <= 1'b0;
      end
    end
  end

  assign top1 = r_top1;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Scoreboard bench for sprite_anim_ctrl: directed ticks push expected
// outputs, a monitor pops and compares after each tick or probe edge.
module tb_sprite_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] req1 = 4'd0;
  logic [3:0] req2 = 4'd0;
  logic       hit1 = 1'b0;
  logic       hit2 = 1'b0;
  logic [3:0] sel1;
  logic [3:0] sel2;
  logic       busy1;
  logic       busy2;
  logic       top1;
  logic       probe = 1'b0;

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       b1;
    logic       b2;
    logic       t;
    string      nm;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  sprite_anim_ctrl #(
    .HOLD_START(4),
    .HOLD_END  (3),
    .HOLD_PULL (5),
    .HOLD_HIT  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .req1      (req1),
    .req2      (req2),
    .hit1      (hit1),
    .hit2      (hit2),
    .sel1      (sel1),
    .sel2      (sel2),
    .busy1     (busy1),
    .busy2     (busy2),
    .top1      (top1)
  );

  always #5 clk = ~clk;

  // Expected select index i ticks after an attack/directional start.
  function automatic logic [3:0] atk_sel(input int i);
    return (i < 4) ? 4'd3 : (i < 7) ? 4'd4 : (i < 12) ? 4'd5 : 4'd0;
  endfunction

  function automatic logic [3:0] dir_sel(input int i);
    return (i < 4) ? 4'd7 : (i < 7) ? 4'd8 : (i < 12) ? 4'd9 : 4'd0;
  endfunction

  task automatic push_exp(input logic [3:0] e1, input logic [3:0] e2,
                          input logic eb1, input logic eb2, input logic et,
                          input string nm);
    exp_t e;
    e.s1 = e1; e.s2 = e2; e.b1 = eb1; e.b2 = eb2; e.t = et; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic tick(input logic h1, input logic h2,
                      input logic [3:0] e1, input logic [3:0] e2,
                      input logic eb1, input logic eb2, input logic et,
                      input string nm);
    @(negedge clk);
    frame_tick = 1'b1;
    hit1 = h1;
    hit2 = h2;
    push_exp(e1, e2, eb1, eb2, et, nm);
    @(negedge clk);
    frame_tick = 1'b0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic probe_chk(input logic [3:0] e1, input logic [3:0] e2,
                           input logic eb1, input logic eb2, input logic et,
                           input string nm);
    @(negedge clk);
    probe = 1'b1;
    push_exp(e1, e2, eb1, eb2, et, nm);
    @(negedge clk);
    probe = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick || probe) begin
        #1;
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL no_expectation: DUT output at %0t with empty scoreboard", $time);
        end else begin
          e = q.pop_front();
          if ({sel1, sel2, busy1, busy2, top1} !== {e.s1, e.s2, e.b1, e.b2, e.t}) begin
            n_fail++;
            $display("FAIL %s: got sel1=%0d sel2=%0d busy1=%0b busy2=%0b top1=%0b, expected sel1=%0d sel2=%0d busy1=%0b busy2=%0b top1=%0b",
                     e.nm, sel1, sel2, busy1, busy2, top1, e.s1, e.s2, e.b1, e.b2, e.t);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    probe_chk(0, 0, 0, 0, 1, "reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Plain attack: 4/3/5 frame phases then idle.
    req1 = 4'd3;
    tick(0, 0, 3, 0, 1, 0, 1, "atk_start");
    req1 = 4'd0;
    for (int i = 1; i <= 12; i++)
      tick(0, 0, atk_sel(i), 0, (i < 12), 0, 1, "atk_seq");

    // Mid-frame request changes: only the value at the tick matters.
    @(negedge clk); req1 = 4'd1;
    @(negedge clk); req1 = 4'd2;
    probe_chk(0, 0, 0, 0, 1, "no_tick_hold");
    tick(0, 0, 2, 0, 0, 0, 1, "walkback");
    req1 = 4'd9;
    tick(0, 0, 0, 0, 0, 0, 1, "invalid_req");
    req1 = 4'd5;
    tick(0, 0, 6, 0, 0, 0, 1, "block");
    req1 = 4'd0;
    tick(0, 0, 0, 0, 0, 0, 1, "idle");

    // Player 2 directional, hit mid-frame during DIR_END.
    req2 = 4'd4;
    tick(0, 0, 0, 7, 0, 1, 0, "dir_start");
    req2 = 4'd0;
    for (int i = 1; i <= 4; i++)
      tick(0, 0, 0, dir_sel(i), 0, 1, 0, "dir_seq");
    @(negedge clk); hit2 = 1'b1;
    @(negedge clk); hit2 = 1'b0;
    probe_chk(0, 8, 0, 1, 0, "hit2_pending");
    req2 = 4'd1;
    for (int i = 0; i < 8; i++)
      tick(0, 0, 0, 10, 0, 1, 0, "hit2_hold");
    tick(0, 0, 0, 1, 0, 0, 0, "hit2_expire");
    tick(0, 0, 0, 1, 0, 0, 0, "no_resume");
    req2 = 4'd0;
    tick(0, 0, 0, 0, 0, 0, 0, "p2_idle");

    // Coincident hits on player 1, the second restarting the hold.
    tick(1, 0, 10, 0, 1, 0, 0, "hit1_a");
    tick(0, 0, 10, 0, 1, 0, 0, "hit1_hold");
    tick(0, 0, 10, 0, 1, 0, 0, "hit1_hold");
    tick(1, 0, 10, 0, 1, 0, 0, "hit1_b");
    for (int i = 4; i <= 10; i++)
      tick(0, 0, 10, 0, 1, 0, 0, "hit1_hold");
    req1 = 4'd3;
    tick(0, 0, 3, 0, 1, 0, 1, "hit_to_atk");
    req1 = 4'd0;
    for (int i = 1; i <= 7; i++)
      tick(0, 0, atk_sel(i), 0, 1, 0, 1, "atk_seq2");

    // Reset while in ATK_PULL.
    rst = 1'b1;
    probe_chk(0, 0, 0, 0, 1, "rst_mid");
    @(negedge clk);
    rst = 1'b0;
    req1 = 4'd5;
    tick(0, 0, 6, 0, 0, 0, 1, "post_rst_block");
    req1 = 4'd0;

    // Draw priority.
    req2 = 4'd3;
    tick(0, 0, 0, 3, 0, 1, 0, "p2_solo");
    req2 = 4'd0;
    for (int i = 1; i <= 12; i++)
      tick(0, 0, 0, atk_sel(i), 0, (i < 12), 0, "p2_seq");
    req1 = 4'd3;
    req2 = 4'd4;
    tick(0, 0, 3, 7, 1, 1, 0, "both_start");
    req1 = 4'd0;
    req2 = 4'd0;
    for (int i = 1; i <= 12; i++)
      tick(0, 0, atk_sel(i), dir_sel(i), (i < 12), (i < 12), 0, "both_seq");
    req1 = 4'd3;
    tick(0, 0, 3, 0, 1, 0, 1, "p1_regain");
    req1 = 4'd0;

    repeat (4) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
